turn_timer: RTL

Per-move countdown timer for the Go board controller, sitting directly downstream of the clock generator. Samples the generator's 1 Hz and 2 Hz square waves on the system clock and counts down the current player's move time in BCD MM:SS. Alternates the player on each placed stone, flags a low-time warning and a timeout, and pulses the generator's 1 Hz reset so second boundaries align with the start of each turn.

---
 rtl/go_timer_pkg.sv | 27 ++
 rtl/sync_edge.sv | 29 ++
 rtl/turn_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/go_timer_pkg.sv
// rtl/go_timer_pkg.sv - shared state encodings, player constants and BCD helper for the move timer
package go_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    // Minutes/seconds in plain decimal to {M1,M0,S1,S0}.
    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        int m1;
        int m0;
        int s1;
        int s0;
        m1 = (mm / 10) % 10;
        m0 = mm % 10;
        s1 = (ss / 10) % 10;
        s0 = ss % 10;
        return {m1[3:0], m0[3:0], s1[3:0], s0[3:0]};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with a rising-edge pulse from a third flop
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-move BCD countdown with player alternation, pause, warning and timeout
module turn_timer
    import go_timer_pkg::*;
#(
    parameter int LOAD_MM = 1,
    parameter int LOAD_SS = 0,
    parameter int WARN_SS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_level,
    input  logic        half_level,
    input  logic        start,
    input  logic        pause,
    input  logic        stone_placed,
    output logic        sec_rst,
    output logic        player,
    output logic [15:0] time_bcd,
    output logic [1:0]  state,
    output logic        warn,
    output logic        blink,
    output logic        timeout
);

    localparam logic [15:0] LOAD_BCD  = to_bcd(LOAD_MM, LOAD_SS);
    localparam logic        LOAD_ZERO = (LOAD_BCD == 16'h0000);
    localparam logic [6:0]  WARN_LIM  = 7'(WARN_SS);

    logic sec_sync_w;
    logic tick_w;
    logic half_sync_w;
    logic half_rise_w;
    logic unused_w;

    sync_edge u_sec_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (sec_level),
        .level_o (sec_sync_w),
        .rise_o  (tick_w)
    );

    sync_edge u_half_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (half_level),
        .level_o (half_sync_w),
        .rise_o  (half_rise_w)
    );

    assign unused_w = sec_sync_w ^ half_rise_w;

    state_t      state_q, state_d;
    logic        player_q, player_d;
    logic [15:0] time_q, time_d;
    logic        sec_rst_q, sec_rst_d;
    logic        timeout_q;

    // One-second BCD decrement with the S0 -> S1 -> M0 -> M1 borrow chain.
    logic [15:0] dec_w;
    logic [3:0]  m1_w, m0_w, s1_w, s0_w;

    always_comb begin
        {m1_w, m0_w, s1_w, s0_w} = time_q;
        if (s0_w != 4'd0) begin
            s0_w = s0_w - 4'd1;
        end else begin
            s0_w = 4'd9;
            if (s1_w != 4'd0) begin
                s1_w = s1_w - 4'd1;
            end else begin
                s1_w = 4'd5;
                if (m0_w != 4'd0) begin
                    m0_w = m0_w - 4'd1;
                end else begin
                    m0_w = 4'd9;
                    m1_w = m1_w - 4'd1;
                end
            end
        end
        dec_w = {m1_w, m0_w, s1_w, s0_w};
    end

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        time_d    = time_q;
        sec_rst_d = 1'b0;
        if (start) begin
            state_d   = LOAD_ZERO ? ST_TIMEOUT : ST_RUNNING;
            player_d  = BLACK;
            time_d    = LOAD_BCD;
            sec_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUNNING: begin
                    if (stone_placed) begin
                        player_d  = ~player_q;
                        time_d    = LOAD_BCD;
                        sec_rst_d = 1'b1;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick_w) begin
                        time_d = dec_w;
                        if (dec_w == 16'h0000) begin
                            state_d = ST_TIMEOUT;
                        end
                    end
                end
                ST_PAUSED: begin
                    // Resume restarts the generator so the partial second is dropped.
                    if (pause) begin
                        state_d   = ST_RUNNING;
                        sec_rst_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            player_q  <= BLACK;
            time_q    <= LOAD_BCD;
            sec_rst_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            time_q    <= time_d;
            sec_rst_q <= sec_rst_d;
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end

    logic [6:0] ss_dec_w;

    assign ss_dec_w = ({3'b000, time_q[7:4]} * 7'd10) + {3'b000, time_q[3:0]};
    assign warn     = (state_q == ST_RUNNING) && (time_q[15:8] == 8'h00) && (ss_dec_w <= WARN_LIM);
    assign blink    = (warn || (state_q == ST_TIMEOUT)) ? half_sync_w : 1'b1;

    assign sec_rst  = sec_rst_q;
    assign player   = player_q;
    assign time_bcd = time_q;
    assign state    = state_q;
    assign timeout  = timeout_q;

endmodule
